// File: rtl/bit_stream_deserializer_pkg.sv
// Shared constants and state encoding for the serial-to-parallel deserializer.
package bit_stream_deserializer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/bit_stream_deserializer_if.sv
// Bundles the serial input stream and the word-output handshake of the deserializer.
interface bit_stream_deserializer_if
    import bit_stream_deserializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             enable;
    logic             din;
    logic             din_valid;
    logic             word_ready;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             overflow;
    logic [7:0]       word_count;

    modport master (
        output enable, din, din_valid, word_ready,
        input  word_out, word_valid, overflow, word_count
    );

    modport slave (
        input  enable, din, din_valid, word_ready,
        output word_out, word_valid, overflow, word_count
    );

endinterface

// File: rtl/deser_bit_counter.sv
// Counts sampled bits 0..WIDTH-1 and flags the edge that samples the last bit of a word.
module deser_bit_counter
    import bit_stream_deserializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_advance,
    output logic o_complete
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] r_count;

    assign o_complete = i_advance && !i_clear && (r_count == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_advance) begin
            r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/bit_stream_deserializer.sv
// Assembles a qualified serial bit stream into MSB-first words behind a valid/ready
// output register, with a sticky overflow flag and a loaded-word counter.
module bit_stream_deserializer
    import bit_stream_deserializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset_n,
    bit_stream_deserializer_if.slave bus
);

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_wordOut;
    logic             r_wordValid;
    logic             r_overflow;
    logic [7:0]       r_wordCount;

    logic             w_advance;
    logic             w_clear;
    logic             w_complete;
    logic             w_load;
    logic             w_drop;
    logic [WIDTH-1:0] w_fullWord;

    // Bits are only taken once the FSM has settled in SHIFT with enable still high.
    assign w_advance  = (r_state == SHIFT) && bus.enable && bus.din_valid;
    assign w_clear    = !bus.enable;
    assign w_fullWord = {r_shift[WIDTH-2:0], bus.din};
    assign w_load     = w_complete && (!r_wordValid || bus.word_ready);
    assign w_drop     = w_complete && r_wordValid && !bus.word_ready;

    deser_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bitCounter (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_clear    (w_clear),
        .i_advance  (w_advance),
        .o_complete (w_complete)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_wordOut   <= '0;
            r_wordValid <= 1'b0;
            r_overflow  <= 1'b0;
            r_wordCount <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_shift <= '0;
                    if (bus.enable) begin
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!bus.enable) begin
                        r_state <= IDLE;
                        r_shift <= '0;
                    end else if (w_advance) begin
                        r_shift <= w_fullWord;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_shift <= '0;
                end
            endcase

            // A completing word wins over a plain consume on the same edge.
            if (w_load) begin
                r_wordOut   <= w_fullWord;
                r_wordValid <= 1'b1;
                r_wordCount <= r_wordCount + 8'd1;
            end else if (r_wordValid && bus.word_ready) begin
                r_wordValid <= 1'b0;
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.word_out   = r_wordOut;
    assign bus.word_valid = r_wordValid;
    assign bus.overflow   = r_overflow;
    assign bus.word_count = r_wordCount;

endmodule
